// File: rtl/quadrature_lo_pkg.sv
// Shared phase encoding and mode/sideband constants for the quadrature LO generator.
package quadrature_lo_pkg;

    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } phase_t;

    localparam logic MODE_PULSE25  = 1'b0;
    localparam logic MODE_SQUARE50 = 1'b1;

    localparam logic SB_USB = 1'b0;
    localparam logic SB_LSB = 1'b1;

endpackage

// File: rtl/lo_prescaler.sv
// Divisor counter: emits a phase-advance tick every div_act clocks and latches the
// requested divisor only while idle or on the 3->0 phase wrap.
module lo_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             run,
    input  logic             last_phase,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             load
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_eff;

    // A requested divisor of zero is treated as one so the LO never stalls.
    always_comb begin
        div_eff = (div == '0) ? DIV_W'(1) : div;
        tick    = run && (cnt == div_act - DIV_W'(1));
        load    = !en || (tick && last_phase);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt     <= '0;
            div_act <= DIV_W'(1);
        end else begin
            if (!en || !run || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
            if (load) begin
                div_act <= div_eff;
            end
        end
    end

endmodule

// File: rtl/quadrature_lo_gen.sv
// Programmable quadrature LO: four phases of div_act clocks each, decoded to
// 25% one-hot or 50% square I/Q/Ib/Qb with glitch-free registered outputs.
module quadrature_lo_gen
    import quadrature_lo_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             mode,
    input  logic             sb,
    output logic             out_i,
    output logic             out_q,
    output logic             out_ib,
    output logic             out_qb,
    output logic             sync
);

    phase_t phase;
    phase_t phase_nx;
    logic   run;
    logic   run_nx;
    logic   mode_act;
    logic   mode_nx;
    logic   sb_act;
    logic   sb_nx;
    logic   tick;
    logic   load;
    logic   i_nx;
    logic   q_nx;
    logic   ib_nx;
    logic   qb_nx;
    logic   sync_nx;

    lo_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (en),
        .run        (run),
        .last_phase (phase == PH_3),
        .div        (div),
        .tick       (tick),
        .load       (load)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            run      <= 1'b0;
            phase    <= PH_0;
            mode_act <= MODE_PULSE25;
            sb_act   <= SB_USB;
            out_i    <= 1'b0;
            out_q    <= 1'b0;
            out_ib   <= 1'b0;
            out_qb   <= 1'b0;
            sync     <= 1'b0;
        end else begin
            run      <= run_nx;
            phase    <= phase_nx;
            mode_act <= mode_nx;
            sb_act   <= sb_nx;
            out_i    <= i_nx;
            out_q    <= q_nx;
            out_ib   <= ib_nx;
            out_qb   <= qb_nx;
            sync     <= sync_nx;
        end
    end

    // Mode and sideband share the prescaler's load strobe so all settings switch together.
    always_comb begin
        run_nx   = en;
        phase_nx = phase;
        mode_nx  = mode_act;
        sb_nx    = sb_act;
        if (!en) begin
            phase_nx = PH_0;
        end else if (run && tick) begin
            phase_nx = phase_t'(phase + 2'd1);
        end
        if (load) begin
            mode_nx = mode;
            sb_nx   = sb;
        end
    end

    // Decode the next state so the registered outputs track the state with no extra latency.
    always_comb begin
        i_nx    = 1'b0;
        q_nx    = 1'b0;
        ib_nx   = 1'b0;
        qb_nx   = 1'b0;
        sync_nx = run_nx && (phase_nx == PH_0) && (!run || tick);
        if (run_nx) begin
            if (mode_nx == MODE_SQUARE50) begin
                i_nx  = (phase_nx == PH_0) || (phase_nx == PH_1);
                ib_nx = !i_nx;
                if (sb_nx == SB_USB) begin
                    q_nx = (phase_nx == PH_1) || (phase_nx == PH_2);
                end else begin
                    q_nx = (phase_nx == PH_3) || (phase_nx == PH_0);
                end
                qb_nx = !q_nx;
            end else begin
                i_nx  = (phase_nx == PH_0);
                ib_nx = (phase_nx == PH_2);
                q_nx  = (sb_nx == SB_USB) ? (phase_nx == PH_1) : (phase_nx == PH_3);
                qb_nx = (sb_nx == SB_USB) ? (phase_nx == PH_3) : (phase_nx == PH_1);
            end
        end
    end

endmodule

// File: tb/tb_quadrature_lo_gen.sv
// Directed bench for quadrature_lo_gen: a vector table of per-clock expectations
// {i,q,ib,qb,sync}, plus hand sequences for divisor change and async reset.
module tb_quadrature_lo_gen;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             en;
    logic [DIV_W-1:0] div;
    logic             mode;
    logic             sb;
    logic             out_i;
    logic             out_q;
    logic             out_ib;
    logic             out_qb;
    logic             sync;

    typedef struct {
        logic             en;
        logic [DIV_W-1:0] div;
        logic             mode;
        logic             sb;
        logic [4:0]       exp;
    } vec_t;

    vec_t vecs[$];
    int   vecCount  = 0;
    int   missCount = 0;
    int   syncCount = 0;
    int   syncAt[3];

    quadrature_lo_gen #(.DIV_W(DIV_W)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .en     (en),
        .div    (div),
        .mode   (mode),
        .sb     (sb),
        .out_i  (out_i),
        .out_q  (out_q),
        .out_ib (out_ib),
        .out_qb (out_qb),
        .sync   (sync)
    );

    always #5 clk = ~clk;

    task automatic addVec(input int reps, input logic e, input logic [DIV_W-1:0] d,
                          input logic m, input logic s, input logic [4:0] x);
        vec_t v;
        v.en   = e;
        v.div  = d;
        v.mode = m;
        v.sb   = s;
        v.exp  = x;
        repeat (reps) vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic e, input logic [DIV_W-1:0] d,
                                 input logic m, input logic s);
        en   = e;
        div  = d;
        mode = m;
        sb   = s;
    endtask

    function automatic logic [31:0] outWord();
        return {27'd0, out_i, out_q, out_ib, out_qb, sync};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        // Expected word is {i, q, ib, qb, sync}, sampled just after each edge.
        addVec(1, 1'b1, 8'd1, 1'b0, 1'b0, 5'b10001);
        addVec(1, 1'b1, 8'd1, 1'b0, 1'b0, 5'b01000);
        addVec(1, 1'b1, 8'd1, 1'b0, 1'b0, 5'b00100);
        addVec(1, 1'b1, 8'd1, 1'b0, 1'b0, 5'b00010);
        addVec(1, 1'b1, 8'd1, 1'b0, 1'b0, 5'b10001);
        addVec(1, 1'b1, 8'd1, 1'b0, 1'b0, 5'b01000);
        addVec(1, 1'b1, 8'd1, 1'b0, 1'b0, 5'b00100);
        addVec(1, 1'b1, 8'd1, 1'b0, 1'b0, 5'b00010);
        addVec(1, 1'b1, 8'd3, 1'b1, 1'b0, 5'b10011);
        addVec(2, 1'b1, 8'd3, 1'b1, 1'b0, 5'b10010);
        addVec(1, 1'b1, 8'd3, 1'b1, 1'b0, 5'b11000);
        addVec(2, 1'b1, 8'd3, 1'b1, 1'b1, 5'b11000);
        addVec(3, 1'b1, 8'd3, 1'b1, 1'b1, 5'b01100);
        addVec(3, 1'b1, 8'd3, 1'b1, 1'b1, 5'b00110);
        addVec(1, 1'b1, 8'd3, 1'b1, 1'b1, 5'b11001);
        addVec(2, 1'b1, 8'd3, 1'b1, 1'b1, 5'b11000);
        addVec(3, 1'b1, 8'd3, 1'b1, 1'b1, 5'b10010);
        addVec(3, 1'b1, 8'd3, 1'b1, 1'b1, 5'b00110);
        addVec(3, 1'b1, 8'd3, 1'b1, 1'b1, 5'b01100);
        addVec(1, 1'b1, 8'd3, 1'b1, 1'b1, 5'b11001);
        addVec(1, 1'b1, 8'd3, 1'b1, 1'b1, 5'b11000);
        addVec(1, 1'b0, 8'd0, 1'b0, 1'b0, 5'b00000);
        addVec(1, 1'b1, 8'd0, 1'b0, 1'b0, 5'b10001);
        addVec(1, 1'b1, 8'd0, 1'b0, 1'b0, 5'b01000);
        addVec(1, 1'b1, 8'd0, 1'b0, 1'b0, 5'b00100);
        addVec(1, 1'b1, 8'd0, 1'b0, 1'b0, 5'b00010);
        addVec(1, 1'b1, 8'd0, 1'b0, 1'b0, 5'b10001);

        n_rst = 1'b1;
        applyStimulus(1'b0, 8'd1, 1'b0, 1'b0);
        #1 n_rst = 1'b0;
        #1 checkOutput("reset_now", outWord(), 32'd0);
        @(posedge clk);
        #1 checkOutput("reset_edge", outWord(), 32'd0);
        @(negedge clk);
        applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
        n_rst = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].en, vecs[k].div, vecs[k].mode, vecs[k].sb);
            @(posedge clk);
            #1 checkOutput($sformatf("vec%0d", k + 1), outWord(), {27'd0, vecs[k].exp});
        end

        // Divisor change 2 -> 5 requested during phase 1 takes effect at the next wrap.
        applyStimulus(1'b0, 8'd2, 1'b1, 1'b1);
        @(posedge clk);
        #1 checkOutput("idle", outWord(), 32'd0);
        applyStimulus(1'b1, 8'd2, 1'b1, 1'b1);
        syncAt[0] = 0;
        syncAt[1] = 0;
        syncAt[2] = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (sync === 1'b1 && syncCount < 3) begin
                syncAt[syncCount] = k;
                syncCount++;
            end
            if (k == 3) div = 8'd5;
        end
        checkOutput("sync_first", 32'(syncAt[0]), 32'd1);
        checkOutput("sync_gap_div2", 32'(syncAt[1] - syncAt[0]), 32'd8);
        checkOutput("sync_gap_div5", 32'(syncAt[2] - syncAt[1]), 32'd20);
        checkOutput("div5_ph2", outWord(), {27'd0, 5'b00110});

        // Asynchronous reset between edges clears outputs and the latched settings.
        #3 n_rst = 1'b0;
        #1 checkOutput("async_rst", outWord(), 32'd0);
        applyStimulus(1'b1, 8'd1, 1'b1, 1'b1);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1 checkOutput("post_rst_ph0", outWord(), {27'd0, 5'b10001});
        @(posedge clk);
        #1 checkOutput("post_rst_ph1", outWord(), {27'd0, 5'b01000});

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
